// File: rtl/single_macc_frac_decim_pkg.sv
// Shared widths, tap-control bundle and the output round/saturate helper
// for the single-MACC rational resampler.
package single_macc_frac_decim_pkg;

    localparam int DATA_W     = 18;
    localparam int COEF_W     = 18;
    localparam int PROD_W     = 36;
    localparam int ACC_W      = 40;
    localparam int ADDR_W     = 4;
    localparam int NUM_COEFFS = 16;

    localparam logic signed [ACC_W:0] ROUND_BIAS = 41'sd65536;
    localparam logic signed [ACC_W:0] SAT_MAX    = 41'sd131071;
    localparam logic signed [ACC_W:0] SAT_MIN    = -41'sd131072;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tapCtl_t;

    // Round half-up at bit 17, then clip into the 18-bit signed output range.
    function automatic logic signed [DATA_W-1:0] roundSat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] biased;
        logic signed [ACC_W:0] scaled;
        biased = {acc[ACC_W-1], acc} + ROUND_BIAS;
        scaled = biased >>> 17;
        if (scaled > SAT_MAX) begin
            return SAT_MAX[DATA_W-1:0];
        end else if (scaled < SAT_MIN) begin
            return SAT_MIN[DATA_W-1:0];
        end else begin
            return scaled[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sfd_macc.sv
// Pipelined 18x18 multiply, 40-bit accumulate and round/saturate stage;
// tap-control flags travel alongside the data to frame each output.
module sfd_macc
    import single_macc_frac_decim_pkg::*;
(
    input  logic                     Clk_i,
    input  logic                     Rst_i,
    input  logic signed [COEF_W-1:0] Coeff_i,
    input  logic signed [DATA_W-1:0] Sample_i,
    input  tapCtl_t                  Tap_i,
    output logic signed [DATA_W-1:0] Data_o,
    output logic                     DataValid_o
);

    logic signed [PROD_W-1:0] prod_r;
    tapCtl_t                  prodCtl_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic                     accDone_r;

    // Multiply stage.
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            prod_r    <= '0;
            prodCtl_r <= '0;
        end else begin
            prod_r    <= Coeff_i * Sample_i;
            prodCtl_r <= Tap_i;
        end
    end

    // Accumulate stage; the first tap of an output reloads instead of adding.
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            acc_r     <= '0;
            accDone_r <= 1'b0;
        end else begin
            if (prodCtl_r.valid) begin
                acc_r <= prodCtl_r.first ? ACC_W'(prod_r) : acc_r + ACC_W'(prod_r);
            end else begin
                acc_r <= acc_r;
            end
            accDone_r <= prodCtl_r.valid & prodCtl_r.last;
        end
    end

    // Output register: Data_o holds its last value between strobes.
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            Data_o      <= '0;
            DataValid_o <= 1'b0;
        end else if (accDone_r) begin
            Data_o      <= roundSat(acc_r);
            DataValid_o <= 1'b1;
        end else begin
            Data_o      <= Data_o;
            DataValid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/single_macc_frac_decim.sv
// L/M polyphase FIR resampler: coefficient and delay-line RAMs, phase
// scheduler and tap sequencer feeding a single MACC.
module single_macc_frac_decim
    import single_macc_frac_decim_pkg::*;
#(
    parameter int InterpolationK = 2,
    parameter int DecimationK    = 3
) (
    input  logic                     Clk_i,
    input  logic                     Rst_i,
    input  logic                     CoeffClk_i,
    input  logic [ADDR_W-1:0]        CoeffAddr_i,
    input  logic signed [COEF_W-1:0] CoeffData_i,
    input  logic                     CoeffWr_i,
    input  logic signed [DATA_W-1:0] Data_i,
    input  logic                     DataNd_i,
    output logic signed [DATA_W-1:0] Data_o,
    output logic                     DataValid_o
);

    localparam int TapsPerPhase = NUM_COEFFS / InterpolationK;
    localparam int TAP_W        = (TapsPerPhase > 1) ? $clog2(TapsPerPhase) : 1;
    localparam int D_W          = $clog2(DecimationK + InterpolationK) + 1;

    logic unusedCoeffClk_s;
    assign unusedCoeffClk_s = CoeffClk_i;

    logic signed [COEF_W-1:0] coeffMem_r [NUM_COEFFS];
    logic signed [DATA_W-1:0] lineMem_r  [NUM_COEFFS];
    logic signed [COEF_W-1:0] coeffRd_r;
    logic signed [DATA_W-1:0] lineRd_r;

    logic [ADDR_W-1:0] wrPtr_r;
    logic [D_W-1:0]    phaseOff_r;
    logic              primed_r;
    logic              tapActive_r;
    logic [TAP_W-1:0]  tapCnt_r;
    logic [ADDR_W-1:0] phase_r;
    logic [ADDR_W-1:0] newest_r;
    tapCtl_t           tapCtl_r;

    logic [D_W-1:0]    dEff_s;
    logic              due_s;
    logic              start_s;
    logic              lastTap_s;
    logic [ADDR_W-1:0] coeffAddr_s;
    logic [ADDR_W-1:0] lineAddr_s;

    // Phase decision for an arriving sample and the RAM read addresses of the current tap.
    always_comb begin
        dEff_s = '0;
        if (primed_r) begin
            dEff_s = phaseOff_r - D_W'(InterpolationK);
        end else begin
            dEff_s = '0;
        end
        due_s       = (dEff_s < D_W'(InterpolationK));
        start_s     = DataNd_i && due_s && !tapActive_r;
        lastTap_s   = (tapCnt_r == TAP_W'(TapsPerPhase - 1));
        coeffAddr_s = phase_r + ADDR_W'(InterpolationK) * ADDR_W'(tapCnt_r);
        lineAddr_s  = newest_r - ADDR_W'(tapCnt_r);
    end

    // Coefficient and delay-line RAMs; reads return the pre-write contents on a collision.
    always_ff @(posedge Clk_i) begin
        if (CoeffWr_i && Rst_i) begin
            coeffMem_r[CoeffAddr_i] <= CoeffData_i;
        end
        if (DataNd_i && Rst_i) begin
            lineMem_r[wrPtr_r] <= Data_i;
        end
        coeffRd_r <= coeffMem_r[coeffAddr_s];
        lineRd_r  <= lineMem_r[lineAddr_s];
    end

    // Phase scheduler and tap sequencer.
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            wrPtr_r     <= '0;
            phaseOff_r  <= '0;
            primed_r    <= 1'b0;
            tapActive_r <= 1'b0;
            tapCnt_r    <= '0;
            phase_r     <= '0;
            newest_r    <= '0;
        end else begin
            if (DataNd_i) begin
                wrPtr_r    <= wrPtr_r + ADDR_W'(1);
                primed_r   <= 1'b1;
                phaseOff_r <= due_s ? dEff_s + D_W'(DecimationK) : dEff_s;
            end
            if (start_s) begin
                tapActive_r <= 1'b1;
                tapCnt_r    <= '0;
                phase_r     <= ADDR_W'(dEff_s);
                newest_r    <= wrPtr_r;
            end else if (tapActive_r) begin
                tapActive_r <= !lastTap_s;
                tapCnt_r    <= tapCnt_r + TAP_W'(1);
            end
        end
    end

    // Tap framing flags, aligned with the RAM read registers.
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            tapCtl_r <= '0;
        end else begin
            tapCtl_r.valid <= tapActive_r;
            tapCtl_r.first <= tapActive_r && (tapCnt_r == '0);
            tapCtl_r.last  <= tapActive_r && lastTap_s;
        end
    end

    sfd_macc uMacc (
        .Clk_i       (Clk_i),
        .Rst_i       (Rst_i),
        .Coeff_i     (coeffRd_r),
        .Sample_i    (lineRd_r),
        .Tap_i       (tapCtl_r),
        .Data_o      (Data_o),
        .DataValid_o (DataValid_o)
    );

endmodule

// File: tb/tb_single_macc_frac_decim.sv
// Self-checking bench for single_macc_frac_decim: directed scenarios plus random
// traffic, compared against a behavioural resampler model.
module tb_single_macc_frac_decim;

    localparam int L = 2;
    localparam int M = 3;
    localparam int T = 16 / L;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic [3:0]        coeffAddr = 4'd0;
    logic signed [17:0] coeffData = 18'sd0;
    logic              coeffWr = 1'b0;
    logic signed [17:0] dataIn = 18'sd0;
    logic              dataNd = 1'b0;
    logic signed [17:0] dataOut;
    logic              dataValid;

    always #5 clk = ~clk;

    single_macc_frac_decim #(.InterpolationK(L), .DecimationK(M)) dut (
        .Clk_i       (clk),
        .Rst_i       (rstN),
        .CoeffClk_i  (clk),
        .CoeffAddr_i (coeffAddr),
        .CoeffData_i (coeffData),
        .CoeffWr_i   (coeffWr),
        .Data_i      (dataIn),
        .DataNd_i    (dataNd),
        .Data_o      (dataOut),
        .DataValid_o (dataValid)
    );

    typedef struct {
        longint value;
        int     due;
        bit     known;
    } exp_t;

    int     compared = 0;
    int     mismatched = 0;
    int     cyc = 0;
    longint h [16];
    bit     hKnown [16];
    longint x [16];
    bit     xKnown [16];
    int     wp = 0;
    int     d = 0;
    bit     first = 1'b1;
    bit     started = 1'b0;
    int     lastStart = 0;
    exp_t   expQ [$];

    task automatic checkBit(string tag, logic obs, logic expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s at cycle %0d: observed=%0b expected=%0b", tag, cyc, obs, expv);
        end
    endtask

    task automatic checkWord(string tag, logic signed [17:0] obs, longint expl);
        logic signed [17:0] expv;
        expv = 18'(expl);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    // One clock; the strobe must appear exactly when the oldest pending output is due.
    task automatic tick();
        exp_t e;
        bit   expV;
        @(posedge clk);
        #1;
        cyc++;
        expV = (expQ.size() > 0) && (expQ[0].due == cyc);
        checkBit("valid", dataValid, expV);
        if (expV) begin
            e = expQ.pop_front();
            if (e.known) checkWord("data", dataOut, e.value);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Polyphase dot product over the 16-deep history, then round half-up and clip.
    function automatic exp_t refOutput(int p, int m, int due);
        exp_t   r;
        longint acc = 0;
        bit     known = 1'b1;
        for (int j = 0; j < T; j++) begin
            int k  = p + L * j;
            int xi = (m - j + 16) % 16;
            if (!hKnown[k] || (h[k] != 0 && !xKnown[xi])) known = 1'b0;
            acc += h[k] * x[xi];
        end
        acc = (acc + 65536) >>> 17;
        if (acc > 131071) acc = 131071;
        if (acc < -131072) acc = -131072;
        r.value = acc;
        r.due   = due;
        r.known = known;
        return r;
    endfunction

    task automatic sendSample(longint v);
        int dEff;
        int edgeCyc;
        int m;
        edgeCyc = cyc + 1;
        dEff = first ? 0 : d - L;
        first = 1'b0;
        m = wp;
        x[wp] = v;
        xKnown[wp] = 1'b1;
        wp = (wp + 1) % 16;
        if (dEff < L) begin
            if (!(started && (edgeCyc - lastStart <= T))) begin
                started = 1'b1;
                lastStart = edgeCyc;
                expQ.push_back(refOutput(dEff, m, edgeCyc + T + 3));
            end
            d = dEff + M;
        end else begin
            d = dEff;
        end
        dataIn = 18'(v);
        dataNd = 1'b1;
        tick();
        dataNd = 1'b0;
    endtask

    task automatic writeCoeff(int k, longint v);
        coeffAddr = 4'(k);
        coeffData = 18'(v);
        coeffWr = 1'b1;
        tick();
        coeffWr = 1'b0;
        h[k] = v;
        hKnown[k] = 1'b1;
    endtask

    task automatic resetDut(int n);
        rstN = 1'b0;
        expQ.delete();
        wp = 0;
        d = 0;
        first = 1'b1;
        started = 1'b0;
        idle(n);
        checkWord("rstData", dataOut, 0);
        checkBit("rstValid", dataValid, 1'b0);
        rstN = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            h[i] = 0; hKnown[i] = 1'b0; x[i] = 0; xKnown[i] = 1'b0;
        end
        resetDut(3);

        // Zero coefficients: strobes on two of every three inputs, output stays zero.
        for (int k = 0; k < 16; k++) writeCoeff(k, 0);
        for (int i = 0; i < 18; i++) begin
            sendSample(0);
            idle(15);
        end

        // Impulse through h[k]=k+1, landing on a phase-0 input.
        resetDut(2);
        for (int k = 0; k < 16; k++) writeCoeff(k, k + 1);
        for (int i = 0; i < 18; i++) begin sendSample(0); idle(15); end
        sendSample(131071);
        idle(15);
        for (int i = 0; i < 16; i++) begin sendSample(0); idle(15); end

        // Full-scale input and coefficients must clip, not wrap.
        for (int k = 0; k < 16; k++) writeCoeff(k, 131071);
        for (int i = 0; i < 20; i++) begin sendSample(131071); idle(12); end

        // Negative impulse and the rounding boundary around -2^16.
        resetDut(2);
        for (int k = 0; k < 16; k++) writeCoeff(k, 0);
        writeCoeff(0, -65536);
        for (int i = 0; i < 18; i++) begin sendSample(0); idle(15); end
        sendSample(-131072);
        idle(15);
        writeCoeff(0, 1);
        sendSample(0); idle(15);
        sendSample(0); idle(15);
        sendSample(-65536); idle(15);
        sendSample(0); idle(15);
        sendSample(0); idle(15);
        sendSample(-65537); idle(15);
        sendSample(65535); idle(15);

        // Reset while the MACC is reading taps: no strobe may follow.
        for (int k = 0; k < 16; k++) writeCoeff(k, $urandom_range(0, 262143) - 131072);
        sendSample(12345);
        idle(4);
        resetDut(2);
        idle(15);

        // Inputs three cycles apart: the second output is dropped, later outputs intact.
        sendSample(1000);
        idle(2);
        sendSample(-2000);
        idle(15);
        sendSample(3000); idle(15);
        sendSample(-4000); idle(15);
        sendSample(5000); idle(15);

        // Random coefficients, samples and legal spacing.
        for (int k = 0; k < 16; k++) writeCoeff(k, $urandom_range(0, 262143) - 131072);
        for (int i = 0; i < 40; i++) begin
            sendSample($urandom_range(0, 262143) - 131072);
            idle($urandom_range(T + 3, T + 11));
        end

        idle(20);
        checkBit("drained", expQ.size() == 0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
